// File: rtl/register_pipe_pkg.sv
// Shared constants and helpers for the register_pipe pipeline slice.
package register_pipe_pkg;

  localparam int MIN_DEPTH = 1;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/register_pipe_if.sv
// Handshake bus of register_pipe: upstream push side, downstream pop side, occupancy.
interface register_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);

  logic                                         in_valid;
  logic                                         in_ready;
  logic [WIDTH-1:0]                             in_data;
  logic                                         out_valid;
  logic                                         out_ready;
  logic [WIDTH-1:0]                             out_data;
  logic [register_pipe_pkg::occ_width(DEPTH)-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/register_pipe_stage.sv
// One handshaked pipeline stage: enable-loaded data register plus valid bit.
module register_pipe_stage #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             v;
  logic [WIDTH-1:0] d;

  assign up_ready = !v || dn_ready;
  assign dn_valid = v;
  assign dn_data  = d;

  // Data only loads with a valid word, so bubbles never toggle the register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= 1'b0;
      d <= RESET_VALUE;
    end else if (clear) begin
      v <= 1'b0;
      d <= RESET_VALUE;
    end else if (up_ready) begin
      v <= up_valid;
      if (up_valid) d <= up_data;
    end
  end

endmodule

// File: rtl/register_pipe.sv
// DEPTH-stage valid/ready register chain with bubble collapsing, flush and occupancy count.
module register_pipe
  import register_pipe_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  register_pipe_if.slave    bus
);

  localparam int OW = occ_width(DEPTH);

  if (DEPTH < MIN_DEPTH) begin : g_bad_depth
    $error("register_pipe: DEPTH must be at least %0d", MIN_DEPTH);
  end

  logic          in_rdy;
  logic          acc_in;
  logic          acc_out;
  logic [OW-1:0] occ;

  // Per-stage signals live in their own generate scope so the ready chain
  // is a set of distinct nets rather than one self-dependent vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             rdy;
    logic             dn_rdy;
    logic             v;
    logic [WIDTH-1:0] d;

    if (i == 0) begin : g_first
      assign up_v = bus.in_valid;
      assign up_d = bus.in_data;
    end else begin : g_next
      assign up_v = g_stage[i-1].v;
      assign up_d = g_stage[i-1].d;
    end

    if (i == DEPTH - 1) begin : g_last
      assign dn_rdy = bus.out_ready;
    end else begin : g_mid
      assign dn_rdy = g_stage[i+1].rdy;
    end

    register_pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .up_valid (up_v),
      .up_ready (rdy),
      .up_data  (up_d),
      .dn_valid (v),
      .dn_ready (dn_rdy),
      .dn_data  (d)
    );
  end

  assign in_rdy        = g_stage[0].rdy && !clear;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = g_stage[DEPTH-1].v;
  assign bus.out_data  = g_stage[DEPTH-1].d;
  assign bus.occupancy = occ;

  assign acc_in  = bus.in_valid && in_rdy;
  assign acc_out = g_stage[DEPTH-1].v && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ <= '0;
    end else if (clear) begin
      occ <= '0;
    end else if (acc_in && !acc_out) begin
      occ <= occ + OW'(1);
    end else if (!acc_in && acc_out) begin
      occ <= occ - OW'(1);
    end
  end

endmodule

// File: tb/tb_register_pipe.sv
// Directed vector bench for register_pipe: DEPTH=3/WIDTH=8 table plus DEPTH=1/WIDTH=12 sequence.
module tb_register_pipe;

  logic clk;
  logic reset_n;
  logic clear_a;
  logic clear_b;

  int errors = 0;
  int checks = 0;

  register_pipe_if #(.WIDTH(8),  .DEPTH(3)) bus_a ();
  register_pipe_if #(.WIDTH(12), .DEPTH(1)) bus_b ();

  register_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_a),
    .bus     (bus_a)
  );

  register_pipe #(.WIDTH(12), .DEPTH(1), .RESET_VALUE(12'h000)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_b),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       clr;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic clr, input logic e_ir, input logic e_ov,
                              input logic [7:0] e_od, input logic [1:0] e_occ);
    vec_t r;
    r.iv = iv; r.id = id; r.ordy = ordy; r.clr = clr;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od; r.e_occ = e_occ;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int n;
    bit seen;

    reset_n = 1'b0;
    clear_a = 1'b0;
    clear_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;

    #1;
    chk("reset.in_ready",  32'(bus_a.in_ready),  1);
    chk("reset.out_valid", 32'(bus_a.out_valid), 0);
    chk("reset.out_data",  32'(bus_a.out_data),  0);
    chk("reset.occupancy", 32'(bus_a.occupancy), 0);

    // Expected outputs are those visible before the row's clock edge.
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
    // Pass-through 0x01..0x0A: out_data lags by 3 edges, occupancy settles at 3.
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mk(1, 8'(k), 1, 0, 1, (k >= 4), (k >= 4) ? 8'(k - 3) : 8'h00,
                        (k - 1 < 3) ? 2'(k - 1) : 2'd3));
    // Drain; last data stays on out_data after valid drops.
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h08, 3));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h09, 2));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h0A, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h0A, 0));
    // Backpressure: A4 refused while full, then full-rate pass-through.
    vecs.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 8'h0A, 0));
    vecs.push_back(mk(1, 8'hA2, 0, 0, 1, 0, 8'h0A, 1));
    vecs.push_back(mk(1, 8'hA3, 0, 0, 1, 0, 8'h0A, 2));
    vecs.push_back(mk(1, 8'hA4, 0, 0, 0, 1, 8'hA1, 3));
    vecs.push_back(mk(1, 8'hA4, 0, 0, 0, 1, 8'hA1, 3));
    vecs.push_back(mk(1, 8'hA4, 1, 0, 1, 1, 8'hA1, 3));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA2, 3));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA3, 2));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA4, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hA4, 0));
    // Bubble collapse: 0x11, two idles, 0x22 with out_ready low.
    vecs.push_back(mk(1, 8'h11, 0, 0, 1, 0, 8'hA4, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'hA4, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'hA4, 1));
    vecs.push_back(mk(1, 8'h22, 0, 0, 1, 1, 8'h11, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h11, 2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h11, 2));
    // Fill, then clear with a simultaneous push of 0x55.
    vecs.push_back(mk(1, 8'h33, 0, 0, 1, 1, 8'h11, 2));
    vecs.push_back(mk(1, 8'h55, 0, 1, 0, 1, 8'h11, 3));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
    // Two words in flight for the async reset sequence.
    vecs.push_back(mk(1, 8'h66, 0, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h77, 0, 0, 1, 0, 8'h00, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 2));

    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[r]) begin
      bus_a.in_valid  = vecs[r].iv;
      bus_a.in_data   = vecs[r].id;
      bus_a.out_ready = vecs[r].ordy;
      clear_a         = vecs[r].clr;
      #1;
      chk($sformatf("row%0d.in_ready", r),  32'(bus_a.in_ready),  32'(vecs[r].e_ir));
      chk($sformatf("row%0d.out_valid", r), 32'(bus_a.out_valid), 32'(vecs[r].e_ov));
      chk($sformatf("row%0d.out_data", r),  32'(bus_a.out_data),  32'(vecs[r].e_od));
      chk($sformatf("row%0d.occupancy", r), 32'(bus_a.occupancy), 32'(vecs[r].e_occ));
      @(negedge clk);
    end
    clear_a = 1'b0;

    // Async reset between edges with two words held.
    @(posedge clk);
    #1;
    chk("prereset.occupancy", 32'(bus_a.occupancy), 2);
    chk("prereset.out_data",  32'(bus_a.out_data),  32'h66);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async.out_valid", 32'(bus_a.out_valid), 0);
    chk("async.occupancy", 32'(bus_a.occupancy), 0);
    chk("async.out_data",  32'(bus_a.out_data),  0);
    chk("async.in_ready",  32'(bus_a.in_ready),  1);

    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 8'h88;
    bus_a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
    n = 1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_a.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    chk("postreset.seen",    32'(seen), 1);
    chk("postreset.latency", 32'(n), 3);
    chk("postreset.data",    32'(bus_a.out_data), 32'h88);

    // DEPTH=1, WIDTH=12: full register passes through at full rate.
    @(negedge clk);
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.in_data   = 12'h123;
    bus_b.out_ready = 1'b0;
    #1;
    chk("d1.empty.in_ready",  32'(bus_b.in_ready),  1);
    chk("d1.empty.occupancy", 32'(bus_b.occupancy), 0);
    @(negedge clk);
    bus_b.in_data   = 12'hFFF;
    #1;
    chk("d1.stall.in_ready",  32'(bus_b.in_ready),  0);
    chk("d1.stall.out_data",  32'(bus_b.out_data),  32'h123);
    bus_b.out_ready = 1'b1;
    #1;
    chk("d1.full.in_ready",   32'(bus_b.in_ready),  1);
    chk("d1.full.out_valid",  32'(bus_b.out_valid), 1);
    chk("d1.full.occupancy",  32'(bus_b.occupancy), 1);
    @(negedge clk);
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b0;
    #1;
    chk("d1.next.out_data",   32'(bus_b.out_data),  32'hFFF);
    chk("d1.next.out_valid",  32'(bus_b.out_valid), 1);
    chk("d1.next.occupancy",  32'(bus_b.occupancy), 1);
    chk("d1.next.in_ready",   32'(bus_b.in_ready),  0);
    @(negedge clk);
    chk("d1.hold.out_data",   32'(bus_b.out_data),  32'hFFF);
    chk("d1.hold.out_valid",  32'(bus_b.out_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
